// File: rtl/ita_step_scheduler_pkg.sv
// Shared types for the ITA step scheduler: config struct, step and FSM encodings,
// plus helpers for the fixed Q..OW step order.
package ita_step_scheduler_pkg;

  localparam int unsigned H        = 1;
  localparam int unsigned TileCntW = 32;
  localparam int unsigned NHeadsW  = 8;

  typedef logic [TileCntW-1:0] tile_cnt_t;

  typedef enum logic [2:0] {
    Idle = 3'd0,
    Q    = 3'd1,
    K    = 3'd2,
    V    = 3'd3,
    QK   = 3'd4,
    AV   = 3'd5,
    OW   = 3'd6
  } step_e;

  typedef enum logic [1:0] {
    SchedIdle  = 2'd0,
    SchedIssue = 2'd1,
    SchedWait  = 2'd2,
    SchedFin   = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic               start;
    logic [NHeadsW-1:0] n_heads;
    tile_cnt_t          lin_tiles;
    tile_cnt_t          attn_tiles;
  } ctrl_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns Idle after OW so callers can detect the end of a head.
  function automatic step_e next_step(input step_e s);
    step_e r;
    case (s)
      Q:       r = K;
      K:       r = V;
      V:       r = QK;
      QK:      r = AV;
      AV:      r = OW;
      default: r = Idle;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ita_step_scheduler.sv
// Sequences heads, steps (Q,K,V,QK,AV,OW) and tiles for the ITA datapath, one outstanding
// tile request at a time.
module ita_step_scheduler #(
  parameter int unsigned H        = ita_step_scheduler_pkg::H,
  parameter int unsigned TileCntW = 32
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  ita_step_scheduler_pkg::ctrl_t                   ctrl_i,
  output logic                                            tile_req_valid_o,
  input  logic                                            tile_req_ready_i,
  input  logic                                            tile_done_i,
  output ita_step_scheduler_pkg::step_e                   step_o,
  output logic [ita_step_scheduler_pkg::idx_width(H)-1:0] head_o,
  output logic [TileCntW-1:0]                             tile_idx_o,
  output logic                                            first_tile_o,
  output logic                                            last_tile_o,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic                                            err_o
);
  import ita_step_scheduler_pkg::*;

  localparam int unsigned HeadW    = idx_width(H);
  localparam int unsigned HeadCntW = idx_width(H + 1);

  sched_state_e          state_q, state_d;
  step_e                 step_q, step_d;
  logic [HeadCntW-1:0]   head_q, head_d;
  logic [HeadCntW-1:0]   nheads_q, nheads_d;
  logic [TileCntW-1:0]   tile_q, tile_d;
  logic [TileCntW-1:0]   lin_q, lin_d;
  logic [TileCntW-1:0]   attn_q, attn_d;
  logic                  err_q, err_d;

  logic [TileCntW-1:0]   cfg_lin, cfg_attn, cur_tiles;
  logic [HeadCntW-1:0]   cfg_nheads;
  step_e                 start_step, after_step, restart_step;
  logic                  unused_ctrl;

  function automatic logic [TileCntW-1:0] tiles_of(input step_e s,
                                                   input logic [TileCntW-1:0] lin,
                                                   input logic [TileCntW-1:0] attn);
    return (s == QK || s == AV) ? attn : lin;
  endfunction

  // Advances past steps with zero tiles; yields Idle if nothing is left in this head.
  function automatic step_e skip_empty(input step_e s,
                                       input logic [TileCntW-1:0] lin,
                                       input logic [TileCntW-1:0] attn);
    step_e r;
    r = s;
    for (int i = 0; i < 6; i++) begin
      if (r != Idle && tiles_of(r, lin, attn) == '0) r = next_step(r);
    end
    return r;
  endfunction

  assign cfg_lin      = TileCntW'(ctrl_i.lin_tiles);
  assign cfg_attn     = TileCntW'(ctrl_i.attn_tiles);
  assign cfg_nheads   = HeadCntW'(ctrl_i.n_heads);
  assign unused_ctrl  = ^ctrl_i;

  assign cur_tiles    = tiles_of(step_q, lin_q, attn_q);
  assign start_step   = skip_empty(Q, cfg_lin, cfg_attn);
  assign after_step   = skip_empty(next_step(step_q), lin_q, attn_q);
  assign restart_step = skip_empty(Q, lin_q, attn_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    head_d   = head_q;
    nheads_d = nheads_q;
    tile_d   = tile_q;
    lin_d    = lin_q;
    attn_d   = attn_q;
    err_d    = err_q;

    case (state_q)
      SchedIdle: begin
        if (ctrl_i.start) begin
          nheads_d = cfg_nheads;
          lin_d    = cfg_lin;
          attn_d   = cfg_attn;
          err_d    = 1'b0;
          head_d   = '0;
          tile_d   = '0;
          step_d   = start_step;
          state_d  = (cfg_nheads == '0 || start_step == Idle) ? SchedFin : SchedIssue;
        end
      end
      SchedIssue: begin
        if (tile_req_ready_i) state_d = SchedWait;
      end
      SchedWait: begin
        if (tile_done_i) begin
          state_d = SchedIssue;
          if (tile_q != cur_tiles - TileCntW'(1)) begin
            tile_d = tile_q + TileCntW'(1);
          end else begin
            tile_d = '0;
            if (after_step != Idle) begin
              step_d = after_step;
            end else if (head_q == nheads_q - HeadCntW'(1)) begin
              state_d = SchedFin;
            end else begin
              head_d = head_q + HeadCntW'(1);
              step_d = restart_step;
            end
          end
        end
      end
      SchedFin: begin
        state_d = SchedIdle;
      end
      default: begin
        state_d = SchedIdle;
      end
    endcase

    // A completion is only legal while waiting; the handshake cycle counts as outside WAIT.
    if (tile_done_i && state_q != SchedWait) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SchedIdle;
      step_q   <= Idle;
      head_q   <= '0;
      nheads_q <= '0;
      tile_q   <= '0;
      lin_q    <= '0;
      attn_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      head_q   <= head_d;
      nheads_q <= nheads_d;
      tile_q   <= tile_d;
      lin_q    <= lin_d;
      attn_q   <= attn_d;
      err_q    <= err_d;
    end
  end

  assign busy_o           = (state_q == SchedIssue) || (state_q == SchedWait);
  assign tile_req_valid_o = (state_q == SchedIssue);
  assign done_o           = (state_q == SchedFin);
  assign step_o           = busy_o ? step_q : Idle;
  assign head_o           = head_q[HeadW-1:0];
  assign tile_idx_o       = tile_q;
  assign first_tile_o     = busy_o && (tile_q == '0);
  assign last_tile_o      = busy_o && (tile_q == cur_tiles - TileCntW'(1));
  assign err_o            = err_q;

endmodule

// File: tb/tb_ita_step_scheduler.sv
// Directed and randomized jobs for ita_step_scheduler checked against a nested-loop job model.
module tb_ita_step_scheduler;
  import ita_step_scheduler_pkg::*;

  localparam int unsigned NH = 4;
  localparam int unsigned TW = 32;

  logic        clk = 1'b0;
  logic        rst;
  ctrl_t       ctrl;
  logic        ready, tdone;
  logic        valid_o, first_o, last_o, busy_o, done_o, err_o;
  step_e       step_o;
  logic [1:0]  head_o;
  logic [TW-1:0] tile_o;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    step_e s;
    int    h;
    int    t;
    bit    f;
    bit    l;
  } item_t;

  item_t exp_q[$];

  always #5 clk = ~clk;

  ita_step_scheduler #(.H(NH), .TileCntW(TW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ctrl_i           (ctrl),
    .tile_req_valid_o (valid_o),
    .tile_req_ready_i (ready),
    .tile_done_i      (tdone),
    .step_o           (step_o),
    .head_o           (head_o),
    .tile_idx_o       (tile_o),
    .first_tile_o     (first_o),
    .last_tile_o      (last_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every head walks all six steps in order, each step contributing its tile count.
  task automatic build_model(input int nh, input int lin, input int attn);
    step_e order[6];
    item_t it;
    int    n;
    order = '{Q, K, V, QK, AV, OW};
    exp_q.delete();
    for (int h = 0; h < nh; h++) begin
      for (int i = 0; i < 6; i++) begin
        n = (order[i] == QK || order[i] == AV) ? attn : lin;
        for (int t = 0; t < n; t++) begin
          it.s = order[i];
          it.h = h;
          it.t = t;
          it.f = (t == 0);
          it.l = (t == n - 1);
          exp_q.push_back(it);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_valid"}, valid_o, 0);
    chk({pfx, "_step"}, step_o, Idle);
    chk({pfx, "_head"}, head_o, 0);
    chk({pfx, "_tile"}, tile_o, 0);
    chk({pfx, "_first"}, first_o, 0);
    chk({pfx, "_last"}, last_o, 0);
    chk({pfx, "_busy"}, busy_o, 0);
    chk({pfx, "_done"}, done_o, 0);
    chk({pfx, "_err"}, err_o, 0);
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready after 5 valid cycles. dly 0 = random.
  task automatic run_job(input int nh, input int lin, input int attn, input int rmode,
                         input int dly, input bit mid_start, input bit spurious,
                         input bit abort_k1);
    int    done_at, abort_at, acc, vcnt;
    bit    have_prev, got_done, aborted, mid_done, spur_done, err_next, expect_next, saw_done;
    step_e p_s;
    logic [63:0] p_h, p_t;
    item_t it;

    build_model(nh, lin, attn);
    ctrl.start      = 1'b1;
    ctrl.n_heads    = 8'(nh);
    ctrl.lin_tiles  = 32'(lin);
    ctrl.attn_tiles = 32'(attn);
    ready = 1'b0;
    tdone = 1'b0;
    @(posedge clk); #1;
    ctrl.start = 1'b0;

    done_at = -1; abort_at = -1; acc = 0; vcnt = 0;
    have_prev = 0; got_done = 0; aborted = 0; mid_done = 0; spur_done = 0;
    err_next = 0; expect_next = 1;
    p_s = Idle; p_h = '0; p_t = '0;

    for (int c = 0; c < 3000 && !got_done && !aborted; c++) begin
      tdone = 1'b0;
      ctrl.start = 1'b0;
      if (abort_at == c) begin
        rst = 1'b1;
        ready = 1'b0;
        aborted = 1;
      end else begin
        if (expect_next) begin
          if (exp_q.size() > 0) chk("next_valid_latency", valid_o, 1);
          else chk("done_latency", done_o, 1);
          expect_next = 0;
        end
        if (err_next) begin
          chk("spurious_sets_err", err_o, 1);
          err_next = 0;
        end
        if (c == 0) chk("err_clear_on_start", err_o, 0);

        if (done_o) begin
          chk("fin_busy", busy_o, 0);
          chk("fin_step", step_o, Idle);
          chk("all_tiles_issued", exp_q.size(), 0);
          chk("final_err", err_o, spurious);
          got_done = 1;
        end else begin
          chk("busy", busy_o, 1);
          if (have_prev) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_step", step_o, p_s);
            chk("stall_head", head_o, p_h);
            chk("stall_tile", tile_o, p_t);
          end
          have_prev = 0;
          vcnt = valid_o ? vcnt + 1 : 0;
          if (rmode == 0) ready = 1'b1;
          else if (rmode == 1) ready = ($urandom_range(0, 2) != 0);
          else ready = (vcnt > 5);
          if (done_at == c) begin
            tdone = 1'b1;
            expect_next = 1;
          end
          if (spurious && !spur_done && valid_o && acc == 2) begin
            ready = 1'b0;
            tdone = 1'b1;
            spur_done = 1;
            err_next = 1;
          end
          if (mid_start && !mid_done && busy_o && !valid_o && acc == 1) begin
            ctrl.start      = 1'b1;
            ctrl.n_heads    = 8'd3;
            ctrl.lin_tiles  = 32'd3;
            ctrl.attn_tiles = 32'd3;
            mid_done = 1;
          end
          if (valid_o && ready) begin
            chk("request_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              it = exp_q.pop_front();
              chk("req_step", step_o, it.s);
              chk("req_head", head_o, it.h);
              chk("req_tile", tile_o, it.t);
              chk("req_first", first_o, it.f);
              chk("req_last", last_o, it.l);
              acc++;
              done_at = c + ((dly > 0) ? dly : int'($urandom_range(1, 4)));
              if (abort_k1 && it.s == K && it.t == 1) abort_at = c + 1;
            end
          end else if (valid_o) begin
            have_prev = 1;
            p_s = step_o;
            p_h = 64'(head_o);
            p_t = 64'(tile_o);
          end
        end
      end
      if (!got_done) begin
        @(posedge clk); #1;
      end
    end

    ready = 1'b0;
    tdone = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      check_reset_outputs("abort");
      saw_done = 0;
      repeat (5) begin
        @(posedge clk); #1;
        saw_done |= done_o;
      end
      chk("no_done_after_abort", saw_done, 0);
    end else begin
      chk("job_done", got_done, 1);
      @(posedge clk); #1;
      chk("done_one_cycle", done_o, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    ctrl  = '0;
    ready = 1'b0;
    tdone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(1, 2, 3, 0, 2, 0, 0, 0);   // full order, fixed done delay
    run_job(2, 1, 1, 0, 1, 0, 0, 0);   // two heads, single-tile steps
    run_job(1, 2, 2, 2, 1, 0, 0, 0);   // ready held low in ISSUE
    run_job(1, 1, 0, 0, 1, 0, 0, 0);   // QK/AV skipped
    run_job(0, 2, 2, 0, 1, 0, 0, 0);   // no heads
    run_job(2, 0, 0, 0, 1, 0, 0, 0);   // all steps empty
    run_job(1, 2, 1, 1, 0, 1, 1, 0);   // mid-job start, spurious done in ISSUE
    run_job(1, 2, 1, 0, 2, 0, 0, 1);   // reset during WAIT of K tile 1
    run_job(1, 2, 1, 1, 0, 0, 0, 0);   // fresh job after abort

    // Stray completion while idle is flagged and then cleared by the next start.
    tdone = 1'b1;
    @(posedge clk); #1;
    tdone = 1'b0;
    chk("idle_done_sets_err", err_o, 1);
    chk("idle_done_no_busy", busy_o, 0);

    repeat (12) begin
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
